// File: rtl/branch_sequencer.sv
// Control sequencer for a single conditional-branch instruction: fetch (T0-T2),
// CON evaluation (T3) and conditional PC update (T4-T6), with a bounded memory wait.
module branch_sequencer #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [1:0] cond,
   input  logic       con_branch,
   input  logic       mem_ready,
   output logic [1:0] con_cond,
   output logic       pc_out,
   output logic       mar_in,
   output logic       inc_pc,
   output logic       z_in,
   output logic       zlow_out,
   output logic       pc_in,
   output logic       md_read,
   output logic       mdr_in,
   output logic       mdr_out,
   output logic       ir_in,
   output logic       gra,
   output logic       r_out,
   output logic       con_in,
   output logic       y_in,
   output logic       c_out,
   output logic       alu_add,
   output logic       busy,
   output logic       done,
   output logic       mem_err
);

   typedef enum logic [3:0] {
      IDLE, T0, T1, T2, T3, T4, T5, T6, FIN
   } state_t;

   localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT_MAX);

   state_t     state;
   logic [3:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (!clr) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         con_cond <= 2'b00;
         mem_err  <= 1'b0;
      end else begin
         mem_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  con_cond <= cond;
                  state    <= T0;
               end
            end
            T0: begin
               wait_cnt <= 4'd0;
               state    <= T1;
            end
            // Abort fires in the T1 cycle where the counter has reached the limit.
            T1: begin
               if (mem_ready) begin
                  state <= T2;
               end else if (wait_cnt == WAIT_LIMIT) begin
                  state   <= IDLE;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            T2:      state <= T3;
            T3:      state <= T4;
            T4:      state <= T5;
            T5:      state <= T6;
            T6:      state <= FIN;
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Moore decode; wait_cnt is zero only in the first T1 cycle, so PC loads once.
   always_comb begin
      pc_out   = 1'b0;
      mar_in   = 1'b0;
      inc_pc   = 1'b0;
      z_in     = 1'b0;
      zlow_out = 1'b0;
      pc_in    = 1'b0;
      md_read  = 1'b0;
      mdr_in   = 1'b0;
      mdr_out  = 1'b0;
      ir_in    = 1'b0;
      gra      = 1'b0;
      r_out    = 1'b0;
      con_in   = 1'b0;
      y_in     = 1'b0;
      c_out    = 1'b0;
      alu_add  = 1'b0;
      case (state)
         T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
            z_in   = 1'b1;
         end
         T1: begin
            zlow_out = 1'b1;
            pc_in    = (wait_cnt == 4'd0);
            md_read  = 1'b1;
            mdr_in   = 1'b1;
         end
         T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         T3: begin
            gra    = 1'b1;
            r_out  = 1'b1;
            con_in = 1'b1;
         end
         T4: begin
            pc_out = 1'b1;
            y_in   = 1'b1;
         end
         T5: begin
            c_out   = 1'b1;
            alu_add = 1'b1;
            z_in    = 1'b1;
         end
         T6: begin
            zlow_out = 1'b1;
            pc_in    = con_branch;
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == FIN);

endmodule
